hilo_div: RTL
=============

// Module: hilo_div
// PURPOSE
//  Iterative 32-bit MIPS DIV/DIVU unit and the writer side of the register file HI/LO write port.
//  Sits in EX: accepts one divide from the EX stage and stalls the pipeline while it works.
//  Produces the quotient on lo_o and the remainder on hi_o, with single-cycle hi_we/lo_we pulses.
//  Uses restoring shift-subtract, one quotient bit per cycle.
// PARAMETERS
//  WIDTH  32  operand/result width; the iteration count equals WIDTH
// PORTS
//  clk        in   1      system clock, all state updates on rising edge
//  rst        in   1      synchronous active-high reset
//  start      in   1      request divide; sampled only in IDLE
//  signed_div in   1      1 = DIV (two's complement), 0 = DIVU; captured with start
//  opdata1    in   WIDTH  dividend; captured with start
//  opdata2    in   WIDTH  divisor; captured with start
//  annul      in   1      flush (exception or branch); aborts any in-flight divide
//  stall_req  out  1      holds the pipeline while a divide is in flight
//  hi_we      out  1      HI write strobe, one-cycle pulse
//  lo_we      out  1      LO write strobe, one-cycle pulse
//  hi_o       out  WIDTH  remainder, valid while hi_we=1
//  lo_o       out  WIDTH  quotient, valid while lo_we=1
// BEHAVIOUR
//  Reset: state=IDLE; stall_req=0, hi_we=0, lo_we=0, hi_o=0, lo_o=0; all internal registers cleared.
//  States:
//   IDLE->DIVZERO  on start && !annul && opdata2==0
//   IDLE->BUSY     on start && !annul && opdata2!=0
//    - capture |opdata1| and |opdata2| (abs only if signed_div);
//    - record sign flags and the operation type; load counter=0.
//   BUSY: each cycle shift {rem,quo} left by 1; if rem>=divisor, subtract and set quotient LSB.
//    - Increment counter. When counter==WIDTH-1 in the current cycle -> DONE.
//   DIVZERO -> DONE after 1 cycle. Result: lo=all ones, hi=original opdata1.
//   DONE: hi_we=lo_we=1 for exactly this cycle; hi_o/lo_o hold the results; -> IDLE.
//  Sign fix (signed_div=1), applied on entry to DONE:
//   - quotient is negated if the dividend and divisor signs differ;
//   - remainder takes the sign of the dividend.
//  0x80000000 / 0xFFFFFFFF (signed): quo=0x80000000 and rem=0 (natural wrap, no trap).
//  Latency: start accepted at cycle N; BUSY spans N+1..N+WIDTH; DONE (write pulse) at N+WIDTH+1.
//  stall_req:
//   - combinationally 1 in IDLE when start=1 and annul=0;
//   - registered 1 in BUSY and DIVZERO;
//   - 0 in DONE, so the pipeline advances on the write cycle.
//  Any state with annul=1: next state IDLE, no hi_we/lo_we pulse, stall_req=0 that cycle.
//  DONE with annul=1: the write is suppressed.
//  start in BUSY/DIVZERO/DONE is ignored; no new divide is accepted in the DONE cycle.
//  hi_o/lo_o keep their last values when hi_we/lo_we=0.
//  rst asserted mid-divide: the operation is discarded and no write pulse occurs.
// CONFIGURATION
//  HILO_DIV_SKIP_EN defined:
//   - in IDLE with start, divisor!=0 and |dividend| < |divisor| -> DONE directly (skips BUSY);
//   - result: quo=0, hi=opdata1; write pulse on cycle N+1.
//   - stall_req=1 only combinationally in cycle N.
//  HILO_DIV_SKIP_EN undefined: every nonzero-divisor divide takes the full WIDTH+1 cycles.
// TESTING
//  - DIVU 100/7: start@N -> hi_we=lo_we=1 at N+33 only; lo_o=14, hi_o=2; stall_req=1 for N..N+32.
//  - DIV -7/2: lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
//    DIV 7/-2: lo_o=-3, hi_o=1.
//  - DIV 0x80000000/0xFFFFFFFF: lo_o=0x80000000, hi_o=0; no hang, pulse at N+33.
//  - DIVU 5/0: DIVZERO path; pulse at N+2; lo_o=0xFFFFFFFF, hi_o=5.
//  - annul at N+10 during BUSY: IDLE at N+11, stall_req=0, no we pulse.
//    A new start at N+12 completes normally at N+45.
//  - SKIP_EN: DIVU 3/9 -> pulse at N+1, lo_o=0, hi_o=3.
//    Without the macro: pulse at N+33, same values.

Source files
------------

// File: rtl/hilo_div.sv
// Iterative restoring DIV/DIVU unit that drives the HI/LO write port (remainder on HI, quotient on LO).
// Optional macro HILO_DIV_SKIP_EN: when |dividend| < |divisor|, go straight to the write cycle.
module hilo_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             annul,
    output logic             stall_req,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] quo, rem, dvsr, dvnd_orig;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic             skip;

    always_comb begin
        a_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        b_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    end

`ifdef HILO_DIV_SKIP_EN
    assign skip = (a_abs < b_abs);
`else
    assign skip = 1'b0;
`endif

    // One restoring step: the bit shifted out of quo enters rem; the trial
    // needs one extra bit because rem can be as large as dvsr-1.
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        if (trial >= {1'b0, dvsr}) begin
            rem_nxt = WIDTH'(trial - {1'b0, dvsr});
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        if (annul) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    stall_req = 1'b1;
                    if (opdata2 == '0) state_nxt = DIVZERO;
                    else if (skip)     state_nxt = DONE;
                    else               state_nxt = BUSY;
                end
                BUSY: begin
                    stall_req = 1'b1;
                    if (cnt == LAST) state_nxt = DONE;
                end
                DIVZERO: begin
                    stall_req = 1'b1;
                    state_nxt = DONE;
                end
                DONE: begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Results are loaded into hi_o/lo_o on the transition into DONE and held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo       <= '0;
            rem       <= '0;
            dvsr      <= '0;
            dvnd_orig <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else if (!annul) begin
            case (state)
                IDLE: if (start) begin
                    quo       <= a_abs;
                    rem       <= '0;
                    dvsr      <= b_abs;
                    dvnd_orig <= opdata1;
                    cnt       <= '0;
                    neg_q     <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_r     <= signed_div & opdata1[WIDTH-1];
                    if (opdata2 != '0 && skip) begin
                        lo_o <= '0;
                        hi_o <= opdata1;
                    end
                end
                BUSY: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        lo_o <= neg_q ? -quo_nxt : quo_nxt;
                        hi_o <= neg_r ? -rem_nxt : rem_nxt;
                    end
                end
                DIVZERO: begin
                    lo_o <= '1;
                    hi_o <= dvnd_orig;
                end
                default: ;
            endcase
        end
    end
endmodule
